// File: rtl/mba_nch_pkg.sv
// -----------------------------------------------------------------------------
// mba_pkg
// Shared definitions for the N-channel memory bus arbiter:
//   - state_e : arbiter FSM state encoding (IDLE / GRANT / TURN)
//   - RD, WR  : bus direction constants
//   - clog2() : index width helper, never returns less than 1
// -----------------------------------------------------------------------------
package mba_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/mba_nch_rr_pick.sv
// -----------------------------------------------------------------------------
// mba_rr_pick
// Combinational rotate-priority picker. Scans req_i starting at ptr_i and
// wrapping; the first set bit wins. Tie ptr_i to 0 for fixed priority.
// Ports:
//   req_i   [N_REQ-1:0] : request vector
//   ptr_i   [IW-1:0]    : first index to consider (must be < N_REQ)
//   grant_o [N_REQ-1:0] : one-hot winner, zero when nothing requested
//   idx_o   [IW-1:0]    : winner index, zero when nothing requested
//   found_o             : at least one request present
// -----------------------------------------------------------------------------
module mba_rr_pick
    import mba_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    idx_o,
    output logic             found_o
);

    logic [IW-1:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = IW'((int'(ptr_i) + i) % N_REQ);
            if (!found_o && req_i[pos]) begin
                found_o      = 1'b1;
                idx_o        = pos;
                grant_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mba_nch.sv
// -----------------------------------------------------------------------------
// mba_nch
// N-channel memory bus arbiter. Grants the shared data bus to one requester
// at a time (fixed priority or round-robin), registers the bus direction and
// inserts a turnaround gap after every release. An optional hold limit forces
// the owner off the bus when somebody else is waiting.
//
// Handshake: i_req[n] is a level request; requester n keeps it high until it
// sees o_allow[n], and keeps it high for as long as it wants the bus. Nothing
// is latched, so a request dropped before the IDLE sample is simply lost.
//
// Ports:
//   clk_166M66, mcu_sys_rst_n : clock, asynchronous active-low reset
//   i_req  [N_REQ-1:0]        : level requests
//   i_rw   [N_REQ-1:0]        : requested direction (0 read, 1 write)
//   o_allow [N_REQ-1:0]       : one-hot grant
//   o_data_bus_rw             : registered bus direction
//   o_owner                   : current owner index (valid while o_bus_busy)
//   o_bus_busy                : high in GRANT
//   o_turnaround              : high in TURN
//   o_dbg_state               : FSM state, for observation only
// -----------------------------------------------------------------------------
module mba_nch
    import mba_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int TURN_CYC = 3,
    parameter  int RR_EN    = 1,
    parameter  int MAX_HOLD = 16,
    localparam int OW       = clog2(N_REQ)
) (
    input  logic             clk_166M66,
    input  logic             mcu_sys_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_rw,
    output logic [N_REQ-1:0] o_allow,
    output logic             o_data_bus_rw,
    output logic [OW-1:0]    o_owner,
    output logic             o_bus_busy,
    output logic             o_turnaround,
    output state_e           o_dbg_state
);

    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [3:0] TURN_LAST = 4'((TURN_CYC == 0) ? 0 : TURN_CYC - 1);

    state_e           state_q;
    logic [N_REQ-1:0] allow_q;
    logic             rw_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    ptr_q;
    logic [3:0]       turn_cnt_q;
    logic [7:0]       hold_cnt_q;
    logic             busy_q;
    logic             turn_q;

    logic [OW-1:0]    pick_ptr;
    logic [N_REQ-1:0] win_onehot;
    logic [OW-1:0]    win_idx;
    logic             win_found;
    logic [OW-1:0]    ptr_next;
    logic             others_req;
    logic             hold_hit;
    logic             release_now;

    assign pick_ptr = (RR_EN != 0) ? ptr_q : '0;

    mba_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i   (i_req),
        .ptr_i   (pick_ptr),
        .grant_o (win_onehot),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    assign ptr_next = (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    // allow_q is one-hot on the owner while in GRANT, so masking with it
    // leaves only the competing requests.
    assign others_req  = |(i_req & ~allow_q);
    assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && others_req;
    // Owner drop, direction change and hold expiry all collapse into one release.
    assign release_now = !i_req[owner_q] || (i_rw[owner_q] != rw_q) || hold_hit;

    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            state_q    <= IDLE;
            allow_q    <= '0;
            rw_q       <= RD;
            owner_q    <= '0;
            ptr_q      <= '0;
            turn_cnt_q <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            turn_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q    <= GRANT;
                        allow_q    <= win_onehot;
                        owner_q    <= win_idx;
                        rw_q       <= i_rw[win_idx];
                        hold_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        if (RR_EN != 0) ptr_q <= ptr_next;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        allow_q    <= '0;
                        busy_q     <= 1'b0;
                        turn_cnt_q <= '0;
                        if (TURN_CYC != 0) begin
                            state_q <= TURN;
                            turn_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_LAST)) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                TURN: begin
                    if (turn_cnt_q == TURN_LAST) begin
                        state_q <= IDLE;
                        turn_q  <= 1'b0;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    allow_q <= '0;
                    busy_q  <= 1'b0;
                    turn_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_allow       = allow_q;
    assign o_data_bus_rw = rw_q;
    assign o_owner       = owner_q;
    assign o_bus_busy    = busy_q;
    assign o_turnaround  = turn_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_mba_nch.sv
module tb_mba_nch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 requesters, 3-cycle turnaround, round-robin, hold limit 4
    logic [3:0] req_a = '0, rw_a = '0, allow_a;
    logic       rwo_a, busy_a, turn_a;
    logic [1:0] own_a, st_a;
    // DUT B: same but fixed priority
    logic [3:0] req_b = '0, rw_b = '0, allow_b;
    logic       rwo_b, busy_b, turn_b;
    logic [1:0] own_b, st_b;
    // DUT C: 5 requesters, no turnaround, round-robin, hold limit 2
    logic [4:0] req_c = '0, rw_c = '0, allow_c;
    logic       rwo_c, busy_c, turn_c;
    logic [2:0] own_c;
    logic [1:0] st_c;

    mba_nch #(.N_REQ(4), .TURN_CYC(3), .RR_EN(1), .MAX_HOLD(4)) dut_a (
        .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_req(req_a), .i_rw(rw_a),
        .o_allow(allow_a), .o_data_bus_rw(rwo_a), .o_owner(own_a),
        .o_bus_busy(busy_a), .o_turnaround(turn_a), .o_dbg_state(st_a));

    mba_nch #(.N_REQ(4), .TURN_CYC(3), .RR_EN(0), .MAX_HOLD(4)) dut_b (
        .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_req(req_b), .i_rw(rw_b),
        .o_allow(allow_b), .o_data_bus_rw(rwo_b), .o_owner(own_b),
        .o_bus_busy(busy_b), .o_turnaround(turn_b), .o_dbg_state(st_b));

    mba_nch #(.N_REQ(5), .TURN_CYC(0), .RR_EN(1), .MAX_HOLD(2)) dut_c (
        .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_req(req_c), .i_rw(rw_c),
        .o_allow(allow_c), .o_data_bus_rw(rwo_c), .o_owner(own_c),
        .o_bus_busy(busy_c), .o_turnaround(turn_c), .o_dbg_state(st_c));

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    // Behavioural model: owner (-1 = nobody), remaining gap cycles, cycles held.
    int   m_n[3]  = '{4, 4, 5};
    int   m_t[3]  = '{3, 3, 0};
    int   m_rr[3] = '{1, 0, 1};
    int   m_h[3]  = '{4, 4, 2};
    int   m_owner[3], m_gap[3], m_held[3], m_ptr[3];
    logic m_rw[3];

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_owner[d] = -1; m_gap[d] = 0; m_held[d] = 0; m_ptr[d] = 0; m_rw[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic [7:0] req, input logic [7:0] rw);
        int n, o, j, start;
        bit others, done;
        n = m_n[d];
        if (m_owner[d] >= 0) begin
            o = m_owner[d];
            m_held[d]++;
            others = 0;
            for (int i = 0; i < n; i++) if (i != o && req[i]) others = 1;
            if (!req[o] || rw[o] !== m_rw[d] || (m_h[d] != 0 && m_held[d] >= m_h[d] && others)) begin
                m_owner[d] = -1;
                m_gap[d]   = m_t[d];
            end
        end else if (m_gap[d] > 0) begin
            m_gap[d]--;
        end else begin
            done  = 0;
            start = (m_rr[d] != 0) ? m_ptr[d] : 0;
            for (int k = 0; k < n; k++) begin
                j = (start + k) % n;
                if (!done && req[j]) begin
                    done = 1; m_owner[d] = j; m_held[d] = 0; m_rw[d] = rw[j];
                    if (m_rr[d] != 0) m_ptr[d] = (j + 1) % n;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            model_step(0, 8'(req_a), 8'(rw_a));
            model_step(1, 8'(req_b), 8'(rw_b));
            model_step(2, 8'(req_c), 8'(rw_c));
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_a = '0; rw_a = '0; req_b = '0; rw_b = '0; req_c = '0; rw_c = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic observe(input int d, output logic [7:0] al, output logic rw,
                           output int own, output logic busy, output logic turn);
        case (d)
            0:       begin al = 8'(allow_a); rw = rwo_a; own = int'(own_a); busy = busy_a; turn = turn_a; end
            1:       begin al = 8'(allow_b); rw = rwo_b; own = int'(own_b); busy = busy_b; turn = turn_b; end
            default: begin al = 8'(allow_c); rw = rwo_c; own = int'(own_c); busy = busy_c; turn = turn_c; end
        endcase
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if ({allow_a, rwo_a, own_a, busy_a, turn_a} !== 9'd0) begin
            errors++; $display("FAIL reset_outs_a got %b exp 0", {allow_a, rwo_a, own_a, busy_a, turn_a});
        end
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state_a got %0d exp 0", st_a); end
        checks++; if ({allow_c, rwo_c, own_c, busy_c, turn_c} !== 11'd0) begin
            errors++; $display("FAIL reset_outs_c got %b exp 0", {allow_c, rwo_c, own_c, busy_c, turn_c});
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_a = 4'b0100; rw_a = 4'b0100;
        tick();
        checks++; if (allow_a !== 4'b0100) begin errors++; $display("FAIL single_allow got %b exp 0100", allow_a); end
        checks++; if (rwo_a !== 1'b1) begin errors++; $display("FAIL single_rw got %b exp 1", rwo_a); end
        checks++; if (own_a !== 2'd2) begin errors++; $display("FAIL single_owner got %0d exp 2", own_a); end
        checks++; if (busy_a !== 1'b1 || st_a !== 2'd1) begin
            errors++; $display("FAIL single_busy got %b/%0d exp 1/1", busy_a, st_a);
        end
        req_a = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (turn_a !== 1'b1 || allow_a !== 4'b0 || rwo_a !== 1'b1) begin
                errors++; $display("FAIL single_turn%0d got turn=%b allow=%b rw=%b exp 1/0000/1", i, turn_a, allow_a, rwo_a);
            end
        end
        tick();
        checks++; if (turn_a !== 1'b0 || busy_a !== 1'b0 || st_a !== 2'd0) begin
            errors++; $display("FAIL single_idle got turn=%b busy=%b st=%0d exp 0/0/0", turn_a, busy_a, st_a);
        end
    endtask

    task automatic test_rr_fairness();
        int wait_n, o;
        logic [1:0] e;
        apply_reset();
        exp_q.delete();
        for (int g = 0; g < 5; g++) exp_q.push_back(2'(g % 4));
        req_a = 4'hF; rw_a = 4'h0;
        for (int g = 0; g < 5; g++) begin
            wait_n = 0;
            while (!busy_a && wait_n < 20) begin tick(); wait_n++; end
            checks++;
            if (!busy_a) begin
                errors++; $display("FAIL rr_wait grant %0d got none exp grant", g);
            end else begin
                e = exp_q.pop_front();
                if (own_a !== e || allow_a !== (4'b1 << e)) begin
                    errors++; $display("FAIL rr_order grant %0d got %0d/%b exp %0d", g, own_a, allow_a, e);
                end
                if (g > 0) begin
                    checks++; if (wait_n != 4) begin errors++; $display("FAIL rr_gap got %0d exp 4", wait_n); end
                end
                o = int'(own_a);
                tick();
                req_a[o] = 1'b0;
                tick();
                req_a[o] = 1'b1;
            end
        end
    endtask

    task automatic test_fixed_priority();
        int wait_n, o;
        apply_reset();
        req_b = 4'hF; rw_b = 4'h0;
        for (int g = 0; g < 4; g++) begin
            wait_n = 0;
            while (!busy_b && wait_n < 20) begin tick(); wait_n++; end
            checks++;
            if (!busy_b) begin
                errors++; $display("FAIL fixed_wait grant %0d got none exp grant", g);
            end else begin
                if (own_b !== 2'd0 || allow_b !== 4'b0001) begin
                    errors++; $display("FAIL fixed_order grant %0d got %0d/%b exp 0", g, own_b, allow_b);
                end
                o = int'(own_b);
                tick();
                req_b[o] = 1'b0;
                tick();
                req_b[o] = 1'b1;
            end
        end
    endtask

    task automatic test_hold_limit();
        apply_reset();
        req_a = 4'b0010;
        tick();
        checks++; if (allow_a !== 4'b0010) begin errors++; $display("FAIL hold_first got %b exp 0010", allow_a); end
        req_a = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (allow_a !== 4'b0010) begin errors++; $display("FAIL hold_keep%0d got %b exp 0010", i, allow_a); end
        end
        tick();
        checks++; if (allow_a !== 4'b0 || turn_a !== 1'b1) begin
            errors++; $display("FAIL hold_release got %b/%b exp 0000/1", allow_a, turn_a);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (turn_a !== 1'b1) begin errors++; $display("FAIL hold_turn%0d got %b exp 1", i, turn_a); end
        end
        tick();
        checks++; if (turn_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL hold_idle got %b/%b exp 0/0", turn_a, busy_a);
        end
        tick();
        checks++; if (allow_a !== 4'b1000 || own_a !== 2'd3) begin
            errors++; $display("FAIL hold_next got %b/%0d exp 1000/3", allow_a, own_a);
        end
    endtask

    task automatic test_dir_change();
        int wait_n;
        apply_reset();
        req_a = 4'b0001; rw_a = 4'b0000;
        tick();
        checks++; if (allow_a !== 4'b0001 || rwo_a !== 1'b0) begin
            errors++; $display("FAIL dir_first got %b/%b exp 0001/0", allow_a, rwo_a);
        end
        tick();
        rw_a = 4'b0001;
        tick();
        checks++; if (allow_a !== 4'b0 || turn_a !== 1'b1 || rwo_a !== 1'b0) begin
            errors++; $display("FAIL dir_release got %b/%b/%b exp 0000/1/0", allow_a, turn_a, rwo_a);
        end
        wait_n = 0;
        while (!busy_a && wait_n < 20) begin tick(); wait_n++; end
        checks++; if (wait_n != 4) begin errors++; $display("FAIL dir_gap got %0d exp 4", wait_n); end
        checks++; if (allow_a !== 4'b0001 || rwo_a !== 1'b1) begin
            errors++; $display("FAIL dir_regrant got %b/%b exp 0001/1", allow_a, rwo_a);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req_a = 4'b0100; rw_a = 4'b0100;
        tick();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL midrst_grant got %b exp 1", busy_a); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({allow_a, rwo_a, own_a, busy_a, turn_a} !== 9'd0) begin
            errors++; $display("FAIL midrst_outs got %b exp 0", {allow_a, rwo_a, own_a, busy_a, turn_a});
        end
        req_a = 4'b1111; rw_a = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (allow_a !== 4'b0001 || own_a !== 2'd0) begin
            errors++; $display("FAIL midrst_first got %b/%0d exp 0001/0", allow_a, own_a);
        end
    endtask

    task automatic test_random();
        logic [7:0] al, exp_al;
        logic rw, busy, turn;
        int own;
        apply_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            req_a ^= 4'($urandom & $urandom);
            rw_a  ^= 4'($urandom & $urandom & $urandom);
            req_b ^= 4'($urandom & $urandom);
            rw_b  ^= 4'($urandom & $urandom & $urandom);
            req_c ^= 5'($urandom & $urandom);
            rw_c  ^= 5'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) req_a = 4'hF;
            tick();
            for (int d = 0; d < 3; d++) begin
                observe(d, al, rw, own, busy, turn);
                exp_al = (m_owner[d] >= 0) ? (8'd1 << m_owner[d]) : 8'd0;
                checks++; if (al !== exp_al) begin
                    errors++; $display("FAIL rand_allow dut%0d cyc%0d got %b exp %b", d, cyc, al, exp_al);
                end
                checks++; if (busy !== (m_owner[d] >= 0)) begin
                    errors++; $display("FAIL rand_busy dut%0d cyc%0d got %b exp %b", d, cyc, busy, m_owner[d] >= 0);
                end
                checks++; if (turn !== (m_owner[d] < 0 && m_gap[d] > 0)) begin
                    errors++; $display("FAIL rand_turn dut%0d cyc%0d got %b exp %b", d, cyc, turn, m_owner[d] < 0 && m_gap[d] > 0);
                end
                checks++; if (rw !== m_rw[d]) begin
                    errors++; $display("FAIL rand_rw dut%0d cyc%0d got %b exp %b", d, cyc, rw, m_rw[d]);
                end
                if (m_owner[d] >= 0) begin
                    checks++; if (own !== m_owner[d]) begin
                        errors++; $display("FAIL rand_owner dut%0d cyc%0d got %0d exp %0d", d, cyc, own, m_owner[d]);
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        test_reset();
        test_single();
        test_rr_fairness();
        test_fixed_priority();
        test_hold_limit();
        test_dir_change();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
